// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the EX-stage sequential divider (ex_div_seq).
// Holds the RV32M divide func3 codes, the FSM state encoding, the
// iteration count and a small absolute-value helper.
package ex_div_seq_pkg;

    // RV32M divide/remainder func3 codes
    localparam logic [2:0] FUNC3_DIV  = 3'b100;
    localparam logic [2:0] FUNC3_DIVU = 3'b101;
    localparam logic [2:0] FUNC3_REM  = 3'b110;
    localparam logic [2:0] FUNC3_REMU = 3'b111;

    // One restoring step per quotient bit
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is
    // the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div_seq_div_core.sv
// div_core: unsigned restoring shift-subtract datapath for ex_div_seq.
// A 64-bit {remainder, quotient} register is loaded with the dividend and
// advanced by one quotient bit on every cycle that i_step is high.
module div_core
    import ex_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic [63:0] r_acc;
    logic [31:0] r_divisor;
    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic [63:0] w_next;

    // Trial subtraction of the divisor from the shifted partial remainder.
    // The partial remainder is always below the divisor, so the 33-bit
    // difference is non-negative exactly when bit 32 is clear.
    always_comb begin
        w_trial = r_acc[63:31];
        w_diff  = w_trial - {1'b0, r_divisor};
        if (!w_diff[32]) begin
            w_next = {w_diff[31:0], r_acc[30:0], 1'b1};
        end else begin
            w_next = {r_acc[62:0], 1'b0};
        end
    end

    // Load the operands or advance one restoring step
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc     <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_acc     <= {32'd0, i_dividend};
            r_divisor <= i_divisor;
        end else if (i_step) begin
            r_acc     <= w_next;
        end
    end

    assign o_quotient  = r_acc[31:0];
    assign o_remainder = r_acc[63:32];

endmodule

// File: rtl/ex_div_seq.sv
// ex_div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// FSM IDLE -> PREP -> CALC (32 cycles) -> FIX -> DONE -> IDLE.
// busy stalls IF/ID/EX from the accepting cycle until the DONE cycle.
// Optional macro EX_DIV_FASTPATH_EN: divide-by-zero and signed overflow
// skip CALC/FIX and go from PREP straight to DONE.
// dbg_state exposes the FSM state for observation.
module ex_div_seq
    import ex_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [2:0]  func3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [2:0]  dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ITER_COUNT);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [2:0]       r_func3;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [31:0]      r_result;
    logic             r_done;

    logic        w_signed;
    logic        w_is_rem;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic [31:0] w_special_val;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [31:0] w_final;
    logic        w_load;
    logic        w_step;

    // Operation decode, special-case detection and sign correction
    always_comb begin
        w_signed  = (r_func3 == FUNC3_DIV) || (r_func3 == FUNC3_REM);
        w_is_rem  = (r_func3 == FUNC3_REM) || (r_func3 == FUNC3_REMU);
        w_div0    = (r_op_b == 32'd0);
        w_ovf     = w_signed && (r_op_a == 32'h8000_0000) && (r_op_b == 32'hFFFF_FFFF);
        w_special = w_div0 || w_ovf;
        // Special results are returned verbatim, without sign correction
        if (w_div0) begin
            w_special_val = w_is_rem ? r_op_a : 32'hFFFF_FFFF;
        end else begin
            w_special_val = w_is_rem ? 32'd0 : 32'h8000_0000;
        end
        w_abs_a = (w_signed && r_op_a[31]) ? abs32(r_op_a) : r_op_a;
        w_abs_b = (w_signed && r_op_b[31]) ? abs32(r_op_b) : r_op_b;
        w_q_fix = r_neg_q ? (~w_quo + 32'd1) : w_quo;
        w_r_fix = r_neg_r ? (~w_rem + 32'd1) : w_rem;
        if (w_special) begin
            w_final = w_special_val;
        end else begin
            w_final = w_is_rem ? w_r_fix : w_q_fix;
        end
        w_load = (r_state == ST_PREP);
        w_step = (r_state == ST_CALC);
    end

    div_core u_core (
        .clk         (clk),
        .rstn        (rstn),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_dividend  (w_abs_a),
        .i_divisor   (w_abs_b),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Control FSM with counter, sign flags and registered done/result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_func3  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else if (flush) begin
            // Flush abandons any operation and wins over a same-cycle start
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op_a  <= op_a;
                        r_op_b  <= op_b;
                        r_func3 <= func3;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_neg_q <= w_signed && (r_op_a[31] ^ r_op_b[31]);
                    r_neg_r <= w_signed && r_op_a[31];
                    r_cnt   <= '0;
`ifdef EX_DIV_FASTPATH_EN
                    if (w_special) begin
                        r_result <= w_special_val;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_state  <= ST_CALC;
                    end
`else
                    r_state <= ST_CALC;
`endif
                end
                ST_CALC: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall request: accepting cycle plus every working state before DONE
    always_comb begin
        busy = rstn && ((start && !flush && (r_state == ST_IDLE)) ||
                        (r_state == ST_PREP) || (r_state == ST_CALC) ||
                        (r_state == ST_FIX));
    end

    assign done      = r_done;
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: a countdown/arithmetic reference
// model is compared every cycle against busy, done and result, and
// directed operations pin literal results and latencies.
module tb_ex_div_seq;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;
    localparam int LAT_FULL = 35;
`ifdef EX_DIV_FASTPATH_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = 35;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_err = 0;
    int dut_dones = 0;

    // model state
    int          m_cnt = 0;
    logic [31:0] m_last = '0;
    logic [31:0] exp_q[$];

    ex_div_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .func3     (func3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == F_DIV) || (f3 == F_REM);
    endfunction

    // Reference arithmetic straight from the RV32M rules
    function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic rem_op;
        rem_op = (f3 == F_REM) || (f3 == F_REMU);
        if (b == 32'd0) return rem_op ? a : 32'hFFFF_FFFF;
        if (is_signed_op(f3)) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem_op ? 32'd0 : 32'h8000_0000;
            return rem_op ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return rem_op ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic special;
        special = (b == 32'd0) || (is_signed_op(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return special ? LAT_SPECIAL : LAT_FULL;
    endfunction

    // Model: countdown to the done cycle; m_cnt==1 marks the done cycle
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt = 0;
            exp_q.delete();
        end else if (flush) begin
            m_cnt = 0;
            exp_q.delete();
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt = model_lat(func3, op_a, op_b);
                exp_q.push_back(golden(func3, op_a, op_b));
            end
        end else begin
            m_cnt = m_cnt - 1;
        end
    end

    // Scoreboard compare on every falling edge
    always @(negedge clk) begin
        logic m_busy;
        logic [31:0] e;
        if (done) dut_dones++;
        if (!rstn) begin
            m_last = '0;
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_result", result, 32'd0);
        end else begin
            m_busy = (m_cnt == 0 && start && !flush) || (m_cnt > 1);
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, (m_cnt == 1)});
            if (m_cnt == 1) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e);
                    m_last = e;
                end
            end else begin
                check("result_hold", result, m_last);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit_res, input int lit_lat);
        int k;
        bit seen;
        check("model_vs_literal", golden(f3, a, b), lit_res);
        start = 1'b1;
        func3 = f3;
        op_a  = a;
        op_b  = b;
        tick();
        start = 1'b0;
        op_a  = $urandom();
        op_b  = $urandom();
        seen  = 1'b0;
        k     = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", k, lit_lat);
            check("op_result", result, lit_res);
        end
        tick();
    endtask

    int d0;

    initial begin
        // reset with start held high: busy must stay low
        start = 1'b1;
        func3 = F_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_state", {29'd0, dbg_state}, 32'd0);
        tick();
        tick();
        start = 1'b0;
        rstn  = 1'b1;
        tick();

        // basic and signed cases
        run_op(F_DIVU, 32'd100, 32'd7, 32'd14, LAT_FULL);
        run_op(F_REMU, 32'd100, 32'd7, 32'd2, LAT_FULL);
        run_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_FULL);
        run_op(F_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_FULL);
        run_op(F_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_FULL);
        run_op(F_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, LAT_FULL);
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_FULL);
        run_op(F_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, LAT_FULL);
        // signed overflow
        run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
        run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SPECIAL);
        // overflow operands as unsigned take the normal path
        run_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FULL);
        // divide by zero, no sign correction
        run_op(F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
        run_op(F_REM,  32'd5, 32'd0, 32'd5, LAT_SPECIAL);
        run_op(F_DIV,  32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, LAT_SPECIAL);
        run_op(F_REM,  32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, LAT_SPECIAL);

        // flush in CALC cycle 10
        d0 = dut_dones;
        start = 1'b1;
        func3 = F_DIVU;
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'd3;
        tick();
        start = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_state_idle", {29'd0, dbg_state}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        tick();
        // flush beats start in IDLE
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        repeat (40) tick();
        check("flush_no_done", dut_dones - d0, 32'd0);
        run_op(F_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

        // start held high through DONE: two accepts, two dones
        d0 = dut_dones;
        start = 1'b1;
        func3 = F_DIVU;
        op_a  = 32'd1000;
        op_b  = 32'd10;
        repeat (71) tick();
        start = 1'b0;
        repeat (40) tick();
        check("held_start_dones", dut_dones - d0, 32'd2);

        // reset mid-CALC
        d0 = dut_dones;
        start = 1'b1;
        func3 = F_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        tick();
        start = 1'b0;
        repeat (15) tick();
        rstn = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (45) tick();
        check("midrst_no_done", dut_dones - d0, 32'd0);
        run_op(F_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_FULL);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
